// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access controller: op encoding, FSM states, default widths.
// MEM_ACCESS_CTRL_RMW_EN enables the add-to-memory op (10).
package mem_access_pkg;

    localparam int DEF_DATA_WIDTH = 20;
    localparam int DEF_ADDR_WIDTH = 12;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Ops the controller will execute; everything else is answered with rsp_err.
    function automatic logic op_supported(input logic [1:0] op);
        logic ok;
        ok = (op == OP_LOAD) || (op == OP_STORE);
`ifdef MEM_ACCESS_CTRL_RMW_EN
        ok = ok || (op == OP_ADD);
`endif
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-request memory access controller (load / store / optional add-to-memory) driving a
// synchronous RAM with one-cycle read latency. Add-to-memory built only with MEM_ACCESS_CTRL_RMW_EN.
module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_str,
    output logic                  mem_ld,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   address_nxt;
    logic [DATA_WIDTH-1:0]   data_in_nxt;
    logic                    str_nxt;
    logic                    ld_nxt;
    logic                    valid_nxt;
    logic [DATA_WIDTH-1:0]   rdata_nxt;
    logic                    err_nxt;

    assign req_ready = (state == IDLE);

`ifdef MEM_ACCESS_CTRL_RMW_EN
    logic [1:0] op_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q <= OP_LOAD;
        end else if (req_valid && req_ready) begin
            op_q <= req_op;
        end
    end
`endif

    // mem_data_in doubles as the wdata latch: it carries the add operand until CAPTURE.
    always_comb begin
        state_nxt   = state;
        address_nxt = mem_address;
        data_in_nxt = mem_data_in;
        str_nxt     = 1'b0;
        ld_nxt      = 1'b0;
        valid_nxt   = rsp_valid;
        rdata_nxt   = rsp_rdata;
        err_nxt     = rsp_err;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    address_nxt = req_addr;
                    data_in_nxt = req_wdata;
                    rdata_nxt   = '0;
                    err_nxt     = 1'b0;
                    if (!op_supported(req_op)) begin
                        state_nxt = RESP;
                        valid_nxt = 1'b1;
                        err_nxt   = 1'b1;
                    end else if (req_op == OP_STORE) begin
                        state_nxt = WRITE;
                        str_nxt   = 1'b1;
                    end else begin
                        state_nxt = READ;
                        ld_nxt    = 1'b1;
                    end
                end
            end

            READ: begin
                state_nxt = CAPTURE;
            end

            CAPTURE: begin
                rdata_nxt = mem_data_out;
`ifdef MEM_ACCESS_CTRL_RMW_EN
                if (op_q == OP_ADD) begin
                    state_nxt   = WRITE;
                    str_nxt     = 1'b1;
                    data_in_nxt = mem_data_out + mem_data_in;
                end else begin
                    state_nxt = RESP;
                    valid_nxt = 1'b1;
                end
`else
                state_nxt = RESP;
                valid_nxt = 1'b1;
`endif
            end

            WRITE: begin
                state_nxt = RESP;
                valid_nxt = 1'b1;
            end

            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                end
            end

            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_address <= '0;
            mem_data_in <= '0;
            mem_str     <= 1'b0;
            mem_ld      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            mem_address <= address_nxt;
            mem_data_in <= data_in_nxt;
            mem_str     <= str_nxt;
            mem_ld      <= ld_nxt;
            rsp_valid   <= valid_nxt;
            rsp_rdata   <= rdata_nxt;
            rsp_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural RAM, transaction-level reference memory, random traffic.
// Expectations for op 10 follow MEM_ACCESS_CTRL_RMW_EN.
module tb_mem_access_ctrl;

    localparam int DW    = 20;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic          mem_str;
    logic          mem_ld;
    logic [DW-1:0] mem_data_out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_str(mem_str), .mem_ld(mem_ld),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int i);
        logic [DW-1:0] v;
        v = DW'(i * 1103);
        return v ^ 20'h5A5A5;
    endfunction

    // Behavioural RAM: registered read, write on mem_str.
    logic [DW-1:0] ram [0:DEPTH-1];
    logic          ram_init_done = 1'b0;
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
            ram_init_done <= 1'b1;
        end else begin
            if (mem_ld)  mem_data_out <= ram[mem_address];
            if (mem_str) ram[mem_address] <= mem_data_in;
        end
    end

    int ld_cnt = 0, st_cnt = 0, both_cnt = 0;
    always @(posedge clk) begin
        if (mem_ld)            ld_cnt   <= ld_cnt + 1;
        if (mem_str)           st_cnt   <= st_cnt + 1;
        if (mem_ld && mem_str) both_cnt <= both_cnt + 1;
    end

    logic [DW-1:0] model [0:DEPTH-1];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Issues one request, waits for the response, optionally stalls it, then retires it.
    task automatic run_txn(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int hold, output int lat, output logic [DW-1:0] rdata, output logic err,
                           output int nld, output int nst, output logic stable, output logic post_ok);
        int ld0, st0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
        ld0 = ld_cnt; st0 = st_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = 2'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = rsp_rdata; err = rsp_err; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || req_ready !== 1'b0)
                stable = 1'b0;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        post_ok = (rsp_valid === 1'b0) && (req_ready === 1'b1);
        nld = ld_cnt - ld0; nst = st_cnt - st0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({rsp_valid, rsp_err, mem_ld, mem_str} !== 4'b0)
            $display("FAIL reset_ctrl got %b want 0000", {rsp_valid, rsp_err, mem_ld, mem_str});
        else pass_cnt++;
        total_cnt++;
        if (rsp_rdata !== '0) $display("FAIL reset_rdata got %h want 0", rsp_rdata); else pass_cnt++;
        total_cnt++;
        if (mem_address !== '0) $display("FAIL reset_addr got %h want 0", mem_address); else pass_cnt++;
        total_cnt++;
        if (mem_data_in !== '0) $display("FAIL reset_wdata got %h want 0", mem_data_in); else pass_cnt++;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        int lat, nld, nst; logic [DW-1:0] rd; logic er, st, po;
        run_txn(2'b01, 12'h005, 20'hABCDE, 0, lat, rd, er, nld, nst, st, po);
        model[12'h005] = 20'hABCDE;
        total_cnt++;
        if (lat != 2) $display("FAIL store_latency got %0d want 2", lat); else pass_cnt++;
        total_cnt++;
        if (rd !== '0 || er !== 1'b0) $display("FAIL store_rsp got %h/%b want 0/0", rd, er); else pass_cnt++;
        total_cnt++;
        if (nst != 1 || nld != 0) $display("FAIL store_pulses got st%0d ld%0d want st1 ld0", nst, nld); else pass_cnt++;
        total_cnt++;
        if (ram[12'h005] !== 20'hABCDE) $display("FAIL store_ram got %h want abcde", ram[12'h005]); else pass_cnt++;
        run_txn(2'b00, 12'h005, DW'($urandom), 0, lat, rd, er, nld, nst, st, po);
        total_cnt++;
        if (lat != 3) $display("FAIL load_latency got %0d want 3", lat); else pass_cnt++;
        total_cnt++;
        if (rd !== 20'hABCDE || er !== 1'b0) $display("FAIL load_rsp got %h/%b want abcde/0", rd, er); else pass_cnt++;
        total_cnt++;
        if (nld != 1 || nst != 0) $display("FAIL load_pulses got ld%0d st%0d want ld1 st0", nld, nst); else pass_cnt++;
        total_cnt++;
        if (po !== 1'b1) $display("FAIL load_retire got %b want 1", po); else pass_cnt++;
    endtask

    task automatic test_reserved();
        int lat, nld, nst; logic [DW-1:0] rd; logic er, st, po;
        run_txn(2'b11, 12'h010, DW'($urandom), 0, lat, rd, er, nld, nst, st, po);
        total_cnt++;
        if (lat != 1) $display("FAIL rsvd_latency got %0d want 1", lat); else pass_cnt++;
        total_cnt++;
        if (rd !== '0 || er !== 1'b1) $display("FAIL rsvd_rsp got %h/%b want 0/1", rd, er); else pass_cnt++;
        total_cnt++;
        if (nld != 0 || nst != 0) $display("FAIL rsvd_pulses got ld%0d st%0d want 0 0", nld, nst); else pass_cnt++;
        total_cnt++;
        if (ram[12'h010] !== model[12'h010]) $display("FAIL rsvd_ram got %h want %h", ram[12'h010], model[12'h010]); else pass_cnt++;
    endtask

    task automatic test_add();
        int lat, nld, nst; logic [DW-1:0] rd; logic er, st, po;
        run_txn(2'b01, 12'hFFF, 20'hFFFFF, 0, lat, rd, er, nld, nst, st, po);
        model[12'hFFF] = 20'hFFFFF;
        run_txn(2'b10, 12'hFFF, 20'h00002, 0, lat, rd, er, nld, nst, st, po);
`ifdef MEM_ACCESS_CTRL_RMW_EN
        model[12'hFFF] = 20'h00001;
        total_cnt++;
        if (lat != 4) $display("FAIL add_latency got %0d want 4", lat); else pass_cnt++;
        total_cnt++;
        if (rd !== 20'hFFFFF || er !== 1'b0) $display("FAIL add_rsp got %h/%b want fffff/0", rd, er); else pass_cnt++;
        total_cnt++;
        if (nld != 1 || nst != 1) $display("FAIL add_pulses got ld%0d st%0d want 1 1", nld, nst); else pass_cnt++;
`else
        total_cnt++;
        if (lat != 1) $display("FAIL add_off_latency got %0d want 1", lat); else pass_cnt++;
        total_cnt++;
        if (rd !== '0 || er !== 1'b1) $display("FAIL add_off_rsp got %h/%b want 0/1", rd, er); else pass_cnt++;
        total_cnt++;
        if (nld != 0 || nst != 0) $display("FAIL add_off_pulses got ld%0d st%0d want 0 0", nld, nst); else pass_cnt++;
`endif
        run_txn(2'b00, 12'hFFF, DW'($urandom), 0, lat, rd, er, nld, nst, st, po);
        total_cnt++;
        if (rd !== model[12'hFFF]) $display("FAIL add_readback got %h want %h", rd, model[12'hFFF]); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int lat, nld, nst; logic [DW-1:0] rd; logic er, st, po;
        run_txn(2'b00, 12'h005, DW'($urandom), 5, lat, rd, er, nld, nst, st, po);
        total_cnt++;
        if (st !== 1'b1) $display("FAIL bp_stable got %b want 1", st); else pass_cnt++;
        total_cnt++;
        if (rd !== model[12'h005]) $display("FAIL bp_rdata got %h want %h", rd, model[12'h005]); else pass_cnt++;
        total_cnt++;
        if (nld != 1 || nst != 0) $display("FAIL bp_pulses got ld%0d st%0d want 1 0", nld, nst); else pass_cnt++;
        total_cnt++;
        if (po !== 1'b1) $display("FAIL bp_retire got %b want 1", po); else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, nld, nst, exp_lat, exp_ld, exp_st, bad;
        logic [DW-1:0] rd, exp_rd, w; logic er, st, po, exp_err;
        logic [1:0] op; logic [AW-1:0] a;
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       a = '0;
                1:       a = 12'hFFF;
                default: a = AW'($urandom_range(0, 15));
            endcase
            w = DW'($urandom);
            exp_rd = '0; exp_err = 1'b0; exp_lat = 1; exp_ld = 0; exp_st = 0;
            if (op == 2'b00) begin
                exp_rd = model[a]; exp_lat = 3; exp_ld = 1;
            end else if (op == 2'b01) begin
                model[a] = w; exp_lat = 2; exp_st = 1;
`ifdef MEM_ACCESS_CTRL_RMW_EN
            end else if (op == 2'b10) begin
                exp_rd = model[a]; model[a] = model[a] + w; exp_lat = 4; exp_ld = 1; exp_st = 1;
`endif
            end else begin
                exp_err = 1'b1;
            end
            run_txn(op, a, w, $urandom_range(0, 3), lat, rd, er, nld, nst, st, po);
            total_cnt++;
            if (lat != exp_lat) $display("FAIL rnd%0d_latency op%0d got %0d want %0d", n, op, lat, exp_lat); else pass_cnt++;
            total_cnt++;
            if (rd !== exp_rd) $display("FAIL rnd%0d_rdata op%0d got %h want %h", n, op, rd, exp_rd); else pass_cnt++;
            total_cnt++;
            if (er !== exp_err) $display("FAIL rnd%0d_err op%0d got %b want %b", n, op, er, exp_err); else pass_cnt++;
            total_cnt++;
            if (nld != exp_ld || nst != exp_st)
                $display("FAIL rnd%0d_pulses op%0d got ld%0d st%0d want ld%0d st%0d", n, op, nld, nst, exp_ld, exp_st);
            else pass_cnt++;
            total_cnt++;
            if (st !== 1'b1 || po !== 1'b1) $display("FAIL rnd%0d_handshake got %b%b want 11", n, st, po); else pass_cnt++;
        end
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] !== model[i]) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL ram_contents got %0d mismatching words want 0", bad); else pass_cnt++;
        total_cnt++;
        if (both_cnt != 0) $display("FAIL ld_str_overlap got %0d want 0", both_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        logic seen;
        int ld0;
        @(negedge clk);
        ld0 = ld_cnt;
        req_valid = 1'b1; req_op = 2'b00; req_addr = AW'($urandom); req_wdata = DW'($urandom);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (ld_cnt - ld0 != 1) $display("FAIL abort_read_issued got %0d want 1", ld_cnt - ld0); else pass_cnt++;
        total_cnt++;
        if ({rsp_valid, rsp_err, mem_ld, mem_str, req_ready} !== 5'b00001 || rsp_rdata !== '0 ||
            mem_address !== '0 || mem_data_in !== '0)
            $display("FAIL abort_outputs got %b %h %h %h want 00001 0 0 0",
                     {rsp_valid, rsp_err, mem_ld, mem_str, req_ready}, rsp_rdata, mem_address, mem_data_in);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_no_response got %b want 0", seen); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = init_val(i);
        test_reset();
        test_store_load();
        test_reserved();
        test_add();
        test_backpressure();
        test_random();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
